seg_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment scan controller. Generalises the fixed 8-digit hex scanner to N digits with selectable output polarity. Adds per-digit decimal points and blink, leading-zero suppression, PWM brightness with anti-ghost dead time, and tear-free frame-synchronous data loading. Sits between the frequency-counter result path and the board display pins.

---
 rtl/seg_scan_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan controller with PWM brightness, blink,
// leading-zero suppression and frame-synchronous shadow loading.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int CLK_HZ      = 50000000,
    parameter int SCAN_HZ     = 1000,
    parameter int BLANK_CYC   = 16,
    parameter int BLINK_TICKS = 500,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit SEL_ACT_LOW = 1'b0
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [4*NUM_DIGITS-1:0]   Disp_Data,
    input  logic [NUM_DIGITS-1:0]     Dp_Mask,
    input  logic [NUM_DIGITS-1:0]     Blink_Mask,
    input  logic                      Lz_En,
    input  logic [3:0]                Bright,
    input  logic                      Load,
    output logic [NUM_DIGITS-1:0]     SEL,
    output logic [7:0]                SEG,
    output logic                      Frame_Start
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [7:0]            SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = SEL_ACT_LOW ? {NUM_DIGITS{1'b1}} : '0;

    // Active-low hex font; bit 7 (dp) is 1 here and replaced later.
    function automatic logic [7:0] hex_font(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'h0: code = 8'hC0;
            4'h1: code = 8'hF9;
            4'h2: code = 8'hA4;
            4'h3: code = 8'hB0;
            4'h4: code = 8'h99;
            4'h5: code = 8'h92;
            4'h6: code = 8'h82;
            4'h7: code = 8'hF8;
            4'h8: code = 8'h80;
            4'h9: code = 8'h90;
            4'hA: code = 8'h88;
            4'hB: code = 8'h83;
            4'hC: code = 8'hC6;
            4'hD: code = 8'hA1;
            4'hE: code = 8'h86;
            default: code = 8'h8E;
        endcase
        return code;
    endfunction

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BLK_W-1:0]        blk_cnt_q, blk_cnt_d;
    logic                    blink_ph_q, blink_ph_d;
    logic                    pend_q, pend_d;
    logic [4*NUM_DIGITS-1:0] sh_data_q;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_blink_q;
    logic                    sh_lz_q;
    logic [3:0]              sh_bright_q;
    logic                    fs_pre_q;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [7:0]              seg_q, seg_d;
    logic                    fs_q;

    logic                    tick, wrap, take;
    logic [NUM_DIGITS-1:0]   supp;
    logic                    zero_run;
    logic [3:0]              cur_nib;
    logic                    cur_dp, cur_blk, cur_sup;
    logic [7:0]              code;
    logic [31:0]             on_time, cnt_w;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   sel_act;
    logic [7:0]              seg_act;

    always_comb begin
        tick = (cnt_q == CNT_W'(DIV - 1));
        wrap = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
        take = wrap && (pend_q || Load);

        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (tick) idx_d = wrap ? '0 : idx_q + IDX_W'(1);

        blk_cnt_d  = blk_cnt_q;
        blink_ph_d = blink_ph_q;
        if (tick) begin
            if (blk_cnt_q == BLK_W'(BLINK_TICKS - 1)) begin
                blk_cnt_d  = '0;
                blink_ph_d = ~blink_ph_q;
            end else begin
                blk_cnt_d = blk_cnt_q + BLK_W'(1);
            end
        end

        // Load on the wrap tick itself is consumed immediately.
        pend_d = take ? 1'b0 : (pend_q | Load);
    end

    // A digit is suppressed when it and every digit above it is 0 with no dp.
    always_comb begin
        supp     = '0;
        zero_run = sh_lz_q;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (sh_data_q[4*i +: 4] == 4'h0) && !sh_dp_q[i];
            supp[i]  = (i != 0) && zero_run;
        end
    end

    always_comb begin
        cur_nib = '0;
        cur_dp  = 1'b0;
        cur_blk = 1'b0;
        cur_sup = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib = sh_data_q[4*i +: 4];
                cur_dp  = sh_dp_q[i];
                cur_blk = sh_blink_q[i];
                cur_sup = supp[i];
            end
        end

        on_time = (32'(DIV - BLANK_CYC) * (32'(sh_bright_q) + 32'd1)) >> 4;
        cnt_w   = 32'(cnt_q);
        lit     = (cnt_w >= 32'(BLANK_CYC)) && ((cnt_w - 32'(BLANK_CYC)) < on_time);

        code    = hex_font(cur_nib);
        seg_act = {cur_dp, ~code[6:0]};
        sel_act = NUM_DIGITS'(1) << idx_q;
        if (cur_sup || (blink_ph_q && cur_blk)) seg_act = '0;
        if (!lit) begin
            seg_act = '0;
            sel_act = '0;
        end

        sel_d = SEL_ACT_LOW ? ~sel_act : sel_act;
        seg_d = SEG_ACT_LOW ? ~seg_act : seg_act;
    end

    // Output stage: one clock behind cnt/idx; Frame_Start delayed to match.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            blk_cnt_q   <= '0;
            blink_ph_q  <= 1'b0;
            pend_q      <= 1'b0;
            sh_data_q   <= '0;
            sh_dp_q     <= '0;
            sh_blink_q  <= '0;
            sh_lz_q     <= 1'b0;
            sh_bright_q <= 4'hF;
            fs_pre_q    <= 1'b0;
            sel_q       <= SEL_OFF;
            seg_q       <= SEG_OFF;
            fs_q        <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            blk_cnt_q  <= blk_cnt_d;
            blink_ph_q <= blink_ph_d;
            pend_q     <= pend_d;
            if (take) begin
                sh_data_q   <= Disp_Data;
                sh_dp_q     <= Dp_Mask;
                sh_blink_q  <= Blink_Mask;
                sh_lz_q     <= Lz_En;
                sh_bright_q <= Bright;
            end
            fs_pre_q <= wrap;
            sel_q    <= sel_d;
            seg_q    <= seg_d;
            fs_q     <= fs_pre_q;
        end
    end

    assign SEL         = sel_q;
    assign SEG         = seg_q;
    assign Frame_Start = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: cycle-level behavioural model plus literal frame checks.
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int DIV   = 10;
    localparam int BLANK = 2;
    localparam int BT    = 4;
    localparam int FRAME = DIV * N;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] Disp_Data;
    logic [3:0]  Dp_Mask, Blink_Mask;
    logic        Lz_En;
    logic [3:0]  Bright;
    logic        Load;
    logic [3:0]  SEL;
    logic [7:0]  SEG;
    logic        Frame_Start;

    seg_scan_ctrl #(
        .NUM_DIGITS(N), .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYC(BLANK),
        .BLINK_TICKS(BT), .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b0)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Disp_Data(Disp_Data), .Dp_Mask(Dp_Mask),
        .Blink_Mask(Blink_Mask), .Lz_En(Lz_En), .Bright(Bright), .Load(Load),
        .SEL(SEL), .SEG(SEG), .Frame_Start(Frame_Start)
    );

    always #5 Clk = ~Clk;

    logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    int vec = 0;
    int err = 0;

    // Model: n counts clocks since reset release; shadow mirrors the frame-latched inputs.
    int          n;
    logic [15:0] m_data;
    logic [3:0]  m_dp, m_blk, m_br;
    logic        m_lz, m_pend;
    logic [3:0]  e_sel;
    logic [7:0]  e_seg;
    logic        e_fs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        n      = 0;
        m_data = '0;
        m_dp   = '0;
        m_blk  = '0;
        m_lz   = 1'b0;
        m_br   = 4'hF;
        m_pend = 1'b0;
        e_sel  = '0;
        e_seg  = 8'hFF;
        e_fs   = 1'b0;
    endtask

    task automatic model_eval();
        int c, slot, d, phase, on_t;
        bit lit, sup, dark;
        logic [3:0] nib;
        c     = n % DIV;
        slot  = n / DIV;
        d     = slot % N;
        phase = (slot / BT) % 2;
        on_t  = ((DIV - BLANK) * (int'(m_br) + 1)) / 16;
        lit   = (c >= BLANK) && ((c - BLANK) < on_t);
        sup   = (d != 0) && m_lz && ((m_data >> (4 * d)) == 16'd0) && ((m_dp >> d) == 4'd0);
        dark  = sup || ((phase == 1) && m_blk[d]);
        e_fs  = (n > 0) && ((n % FRAME) == 0);
        if (!lit) begin
            e_sel = 4'd0;
            e_seg = 8'hFF;
        end else begin
            e_sel = 4'(1 << d);
            nib   = m_data[4*d +: 4];
            e_seg = dark ? 8'hFF : (font[nib] & (m_dp[d] ? 8'h7F : 8'hFF));
        end
    endtask

    task automatic model_advance();
        bit wrap;
        wrap = (n % FRAME) == (FRAME - 1);
        if (wrap && (m_pend || Load)) begin
            m_data = Disp_Data;
            m_dp   = Dp_Mask;
            m_blk  = Blink_Mask;
            m_lz   = Lz_En;
            m_br   = Bright;
            m_pend = 1'b0;
        end else if (Load) begin
            m_pend = 1'b1;
        end
        n++;
    endtask

    task automatic cycle();
        @(posedge Clk);
        if (Reset) model_reset();
        else begin
            model_eval();
            model_advance();
        end
        #1;
        check("SEL", 32'(SEL), 32'(e_sel));
        check("SEG", 32'(SEG), 32'(e_seg));
        check("Frame_Start", 32'(Frame_Start), 32'(e_fs));
    endtask

    task automatic wait_fs();
        int k;
        k = 0;
        do begin
            cycle();
            k++;
        end while (Frame_Start !== 1'b1 && k < 100);
        if (Frame_Start !== 1'b1) check("frame_start_timeout", 32'(Frame_Start), 32'd1);
    endtask

    task automatic load_show();
        Load = 1'b1;
        cycle();
        Load = 1'b0;
        wait_fs();
    endtask

    // Current output must be the first clock of a frame; checks all 40 clocks.
    task automatic frame_lit(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                             input logic [7:0] s3, input int last, input int ld_j,
                             input logic [15:0] ld_data);
        logic [7:0] v [4];
        int c, d;
        bit on;
        v[0] = s0; v[1] = s1; v[2] = s2; v[3] = s3;
        for (int j = 0; j < FRAME; j++) begin
            if (j > 0) cycle();
            c  = j % DIV;
            d  = j / DIV;
            on = (c >= 2) && (c <= last);
            check("lit_SEL", 32'(SEL), on ? 32'(1 << d) : 32'd0);
            check("lit_SEG", 32'(SEG), on ? 32'(v[d]) : 32'hFF);
            if (j == ld_j) begin
                Disp_Data = ld_data;
                Load      = 1'b1;
            end else begin
                Load = 1'b0;
            end
        end
    endtask

    task automatic async_reset();
        #2;
        Reset = 1'b1;
        #1;
        check("rst_SEL", 32'(SEL), 32'd0);
        check("rst_SEG", 32'(SEG), 32'hFF);
        check("rst_FS", 32'(Frame_Start), 32'd0);
        model_reset();
        repeat (2) cycle();
        Reset = 1'b0;
    endtask

    logic [7:0] a0, a1;
    int nz;

    initial begin
        Reset      = 1'b0;
        Disp_Data  = '0;
        Dp_Mask    = '0;
        Blink_Mask = '0;
        Lz_En      = 1'b0;
        Bright     = 4'hF;
        Load       = 1'b0;
        model_reset();
        #2;
        Reset = 1'b1;
        #1;
        check("rst0_SEL", 32'(SEL), 32'd0);
        check("rst0_SEG", 32'(SEG), 32'hFF);
        check("rst0_FS", 32'(Frame_Start), 32'd0);
        repeat (3) cycle();
        Reset = 1'b0;

        // First frame after reset shows cleared shadow content.
        cycle();
        frame_lit(8'hC0, 8'hC0, 8'hC0, 8'hC0, 9, -1, 16'h0);

        Disp_Data = 16'h1234;
        load_show();
        frame_lit(8'h99, 8'hB0, 8'hA4, 8'hF9, 9, -1, 16'h0);

        // Mid-frame load must not disturb the frame in progress.
        wait_fs();
        frame_lit(8'h99, 8'hB0, 8'hA4, 8'hF9, 9, 15, 16'hABCD);
        wait_fs();
        frame_lit(8'hA1, 8'hC6, 8'h83, 8'h88, 9, -1, 16'h0);

        Lz_En = 1'b1;
        Disp_Data = 16'h0050;
        load_show();
        frame_lit(8'hC0, 8'h92, 8'hFF, 8'hFF, 9, -1, 16'h0);
        Disp_Data = 16'h0000;
        load_show();
        frame_lit(8'hC0, 8'hFF, 8'hFF, 8'hFF, 9, -1, 16'h0);
        Disp_Data = 16'h0005;
        Dp_Mask   = 4'b0100;
        load_show();
        frame_lit(8'h92, 8'hC0, 8'h40, 8'hFF, 9, -1, 16'h0);

        Lz_En     = 1'b0;
        Dp_Mask   = 4'b0000;
        Disp_Data = 16'h1234;
        Bright    = 4'h7;
        load_show();
        frame_lit(8'h99, 8'hB0, 8'hA4, 8'hF9, 5, -1, 16'h0);
        Bright = 4'h0;
        load_show();
        frame_lit(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1, -1, 16'h0);

        Bright     = 4'hF;
        Blink_Mask = 4'b0001;
        load_show();
        repeat (5) cycle();
        a0 = SEG;
        wait_fs();
        repeat (5) cycle();
        a1 = SEG;
        check("blink_alternates", 32'(((a0 == 8'h99) && (a1 == 8'hFF)) || ((a0 == 8'hFF) && (a1 == 8'h99))), 32'd1);

        repeat (13) cycle();
        async_reset();
        cycle();
        frame_lit(8'hC0, 8'hC0, 8'hC0, 8'hC0, 9, -1, 16'h0);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                nz         = $urandom_range(0, 4);
                Disp_Data  = 16'($urandom) & (16'hFFFF >> (4 * nz));
                Dp_Mask    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
                Blink_Mask = 4'($urandom);
                Lz_En      = 1'($urandom);
                Bright     = 4'($urandom);
            end
            Load = ($urandom_range(0, 15) == 0);
            cycle();
            if (i == 400) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
